// File: rtl/uart_frame_rx.sv
// Oversampling UART receiver: mid-bit sampling with a clocks-per-bit divider,
// 5..9 data bits, optional parity, 1 or 2 stop bits, single-entry valid/ready output.
module uart_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          SIDX_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 sidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr;
  logic                 perr;
  logic                 rx_meta, rx_s, rx_d;

  logic bit_tick, ferr_final, commit, accept;

  assign bit_tick   = (cnt == CNT_LAST);
  assign ferr_final = ferr | ~rx_s;
  assign commit     = (state == STOP) && bit_tick && (sidx == SIDX_LAST);
  assign accept     = !valid || ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the sync chain resets to the idle (high) line level so
  // reset release cannot fabricate a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sidx       <= 1'b0;
      shreg      <= '0;
      ferr       <= 1'b0;
      perr       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      // A commit in the same cycle as a consumer handshake overrides the drop of valid.
      if (commit) begin
        if (accept) begin
          data_out   <= shreg;
          frame_err  <= ferr_final;
          parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt   <= '0;
              idx   <= '0;
              sidx  <= 1'b0;
              ferr  <= 1'b0;
              perr  <= 1'b0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          cnt <= bit_tick ? '0 : cnt + CW'(1);
          if (bit_tick) begin
            shreg[idx] <= rx_s;
            if (idx == IDX_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
            else                 idx   <= idx + IW'(1);
          end
        end
        PARITY: begin
          cnt <= bit_tick ? '0 : cnt + CW'(1);
          if (bit_tick) begin
            perr  <= (^shreg) ^ rx_s ^ ODD;
            state <= STOP;
          end
        end
        STOP: begin
          cnt <= bit_tick ? '0 : cnt + CW'(1);
          if (bit_tick) begin
            ferr <= ferr_final;
            // Leaving mid-stop lets a back-to-back start edge be caught.
            if (sidx == SIDX_LAST) state <= IDLE;
            else                   sidx  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three configurations (8N1, 8E1, 7N2) driven with
// directed and random frames, checked against frame-level expectations.
module tb_uart_frame_rx;

  localparam int C = 16;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rx_l;
  logic [2:0] rdy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] v, fe, pe, ov;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rec_t q0[$], q1[$], q2[$];
  int   ov_cnt0 = 0;
  int   rise0 = -1, fall0 = -1, rise2 = -1;
  logic [2:0] v_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_frame_rx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .rx(rx_l[0]), .ready(rdy[0]), .data_out(d0),
    .valid(v[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

  uart_frame_rx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .rx(rx_l[1]), .ready(rdy[1]), .data_out(d1),
    .valid(v[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

  uart_frame_rx #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .rx(rx_l[2]), .ready(rdy[2]), .data_out(d2),
    .valid(v[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));

  function automatic rec_t mk(input logic [8:0] d, input logic f, input logic p, input int c);
    rec_t r;
    r.data = d; r.fe = f; r.pe = p; r.cyc = c;
    return r;
  endfunction

  // Scoreboard capture: every accepted word, valid edges and overrun pulses.
  always @(negedge clk) begin
    if (v[0] && rdy[0]) q0.push_back(mk({1'b0, d0}, fe[0], pe[0], cyc));
    if (v[1] && rdy[1]) q1.push_back(mk({1'b0, d1}, fe[1], pe[1], cyc));
    if (v[2] && rdy[2]) q2.push_back(mk({2'b0, d2}, fe[2], pe[2], cyc));
    if (ov[0]) ov_cnt0++;
    if (v[0] && !v_prev[0]) rise0 = cyc;
    if (!v[0] && v_prev[0]) fall0 = cyc;
    if (v[2] && !v_prev[2]) rise2 = cyc;
    v_prev = v;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic take(input int sel, output rec_t r);
    r.data = 'x; r.fe = 1'bx; r.pe = 1'bx; r.cyc = -1;
    case (sel)
      0: if (q0.size() > 0) r = q0.pop_front();
      1: if (q1.size() > 0) r = q1.pop_front();
      default: if (q2.size() > 0) r = q2.pop_front();
    endcase
  endtask

  // Serialises one frame onto rx_l[sel]; t_fall is the cycle the start bit begins.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic pbit, input int nstop,
                            input logic stop_val, output int t_fall);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stop_val);
    t_fall = cyc;
    foreach (bits[i]) begin
      rx_l[sel] = bits[i];
      repeat (C) tick();
    end
    rx_l[sel] = 1'b1;
  endtask

  function automatic logic even_par_err(input logic [8:0] data, input int nbits, input logic pbit);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    return ((ones + int'(pbit)) % 2) != 0;
  endfunction

  initial begin
    rec_t r;
    int   t, base;
    logic [8:0] rd;
    logic rp, rs;

    rx_l  = '1;
    rdy   = '1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_valid", 32'(v), 32'h0);
    check("reset_data0", 32'(d0), 32'h0);
    check("reset_errs", {26'b0, fe, pe}, 32'h0);
    check("reset_overrun", 32'(ov), 32'h0);

    // 8N1 timing: valid exactly one cycle at T0+153 (pin fall + 155).
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, t);
    repeat (20) tick();
    take(0, r);
    check("a5_data", 32'(r.data), 32'hA5);
    check("a5_errs", {30'b0, r.fe, r.pe}, 32'h0);
    check("a5_rise", 32'(rise0), 32'(t + 155));
    check("a5_fall", 32'(fall0), 32'(t + 156));

    // Even parity: 0x03 has two ones, so a parity bit of 1 is an error.
    send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1, t);
    repeat (32) tick();
    take(1, r);
    check("par1_data", 32'(r.data), 32'h03);
    check("par1_pe", 32'(r.pe), 32'h1);
    check("par1_fe", 32'(r.fe), 32'h0);
    send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1, t);
    repeat (32) tick();
    take(1, r);
    check("par0_data", 32'(r.data), 32'h03);
    check("par0_pe", 32'(r.pe), 32'h0);

    // Break: 20 bit times low yields exactly one all-zero frame with a framing error.
    rx_l[0] = 1'b0;
    repeat (20 * C) tick();
    rx_l[0] = 1'b1;
    repeat (40) tick();
    check("brk_count", 32'(q0.size()), 32'h1);
    take(0, r);
    check("brk_data", 32'(r.data), 32'h00);
    check("brk_fe", 32'(r.fe), 32'h1);

    // Overrun: second frame dropped while the first is held.
    rdy[0] = 1'b0;
    base   = ov_cnt0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, t);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, t);
    repeat (20) tick();
    check("ovr_valid", 32'(v[0]), 32'h1);
    check("ovr_hold", 32'(d0), 32'h11);
    check("ovr_pulses", 32'(ov_cnt0 - base), 32'h1);
    rdy[0] = 1'b1;
    repeat (2) tick();
    check("ovr_drain", 32'(v[0]), 32'h0);
    take(0, r);
    check("ovr_data", 32'(r.data), 32'h11);
    check("ovr_left", 32'(q0.size()), 32'h0);

    // Short glitch aborts in START, then a clean frame.
    rx_l[0] = 1'b0;
    repeat (4) tick();
    rx_l[0] = 1'b1;
    repeat (200) tick();
    check("glitch_none", 32'(q0.size()), 32'h0);
    check("glitch_valid", 32'(v[0]), 32'h0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, t);
    repeat (20) tick();
    take(0, r);
    check("glitch_next", 32'(r.data), 32'h5A);

    // Reset during data bit 4 of 0xFF drops the partial frame.
    rx_l[0] = 1'b0;
    repeat (C) tick();
    rx_l[0] = 1'b1;
    repeat (4 * C + C / 2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (200) tick();
    check("rst_none", 32'(q0.size()), 32'h0);
    check("rst_valid", 32'(v[0]), 32'h0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, t);
    repeat (20) tick();
    take(0, r);
    check("rst_next", 32'(r.data), 32'h3C);

    // 7N2: final stop sample at T0+152, valid from T0+153.
    send_frame(2, 9'h07F, 7, 0, 1'b0, 2, 1'b1, t);
    repeat (20) tick();
    take(2, r);
    check("d7_data", 32'(r.data), 32'h7F);
    check("d7_rise", 32'(rise2), 32'(t + 155));
    check("d7_errs", {30'b0, r.fe, r.pe}, 32'h0);

    // Random frames on the parity receiver with occasional bad parity and stop bits.
    for (int n = 0; n < 8; n++) begin
      rd = 9'($urandom_range(0, 255));
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(1, rd, 8, 1, rp, 1, rs, t);
      repeat (3 * C) tick();
      take(1, r);
      check($sformatf("rnd_p_data%0d", n), 32'(r.data), 32'(rd));
      check($sformatf("rnd_p_pe%0d", n), 32'(r.pe), 32'(even_par_err(rd, 8, rp)));
      check($sformatf("rnd_p_fe%0d", n), 32'(r.fe), 32'(!rs));
    end

    // Random 7-bit words on the two-stop-bit receiver.
    for (int n = 0; n < 4; n++) begin
      rd = 9'($urandom_range(0, 127));
      send_frame(2, rd, 7, 0, 1'b0, 2, 1'b1, t);
      repeat (2 * C) tick();
      take(2, r);
      check($sformatf("rnd_7_data%0d", n), 32'(r.data), 32'(rd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
